// File: rtl/sram_bank_if.sv
// Request/response bus of the single-port SRAM bank.
// The master side issues requests and clears; the slave side is the bank.
interface sram_bank_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) ();
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic [DATA_WIDTH-1:0]     req_wdata;
   logic [DATA_WIDTH/8-1:0]   req_be;
   logic                      clr_start;
   logic                      init_busy;
   logic                      rsp_valid;
   logic [DATA_WIDTH-1:0]     rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, clr_start,
      input  req_ready, init_busy, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, clr_start,
      output req_ready, init_busy, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_bank.sv
// Single-port SRAM bank with byte-enabled writes, 1- or 2-cycle reads and a
// self-clearing sweep that initialises every word after reset or on request.
module sram_bank #(
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    OUT_REG    = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic        clk,
   input  logic        rst_n,
   sram_bank_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int BE_W  = DATA_WIDTH / 8;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [0:0]            state_r;
   logic [ADDR_WIDTH-1:0] cnt_r;
   logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

   logic                  req_ready_s;
   logic                  accept_s;
   logic                  rd_accept_s;
   logic                  mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_addr_s;
   logic [DATA_WIDTH-1:0] mem_wdata_s;
   logic [BE_W-1:0]       mem_be_s;

   logic                  rd_valid_r;
   logic [DATA_WIDTH-1:0] rd_data_r;
   logic                  rsp_valid_s;
   logic [DATA_WIDTH-1:0] rsp_rdata_s;

   // Handshake decode; a clear request steals the cycle from any request.
   always_comb begin
      req_ready_s = (state_r == ST_READY) && !bus.clr_start;
      accept_s    = rst_n && bus.req_valid && req_ready_s;
      rd_accept_s = accept_s && !bus.req_we;
   end

   // Sweep / ready state machine.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_CLEAR;
         cnt_r   <= {ADDR_WIDTH{1'b0}};
      end else begin
         case (state_r)
            ST_CLEAR: begin
               if (cnt_r == ADDR_WIDTH'(DEPTH - 1)) begin
                  state_r <= ST_READY;
                  cnt_r   <= {ADDR_WIDTH{1'b0}};
               end else begin
                  cnt_r   <= cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
               end
            end
            ST_READY: begin
               if (bus.clr_start) begin
                  state_r <= ST_CLEAR;
                  cnt_r   <= {ADDR_WIDTH{1'b0}};
               end
            end
            default: begin
               state_r <= ST_CLEAR;
               cnt_r   <= {ADDR_WIDTH{1'b0}};
            end
         endcase
      end
   end

   // Write-port mux: the sweep owns the array while clearing.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_addr_s  = bus.req_addr;
      mem_wdata_s = bus.req_wdata;
      mem_be_s    = bus.req_be;
      if (state_r == ST_CLEAR) begin
         mem_we_s    = rst_n;
         mem_addr_s  = cnt_r;
         mem_wdata_s = INIT_VALUE;
         mem_be_s    = {BE_W{1'b1}};
      end else begin
         mem_we_s    = accept_s && bus.req_we;
      end
   end

   // Array storage; contents are only ever set through the write port.
   always_ff @(posedge clk) begin
      for (int b = 0; b < BE_W; b++) begin
         if (mem_we_s && mem_be_s[b]) begin
            mem_r[mem_addr_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
         end
      end
   end

   // First read stage; data only moves on an accepted read so it holds otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid_r <= 1'b0;
         rd_data_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_valid_r <= rd_accept_s;
         if (rd_accept_s) begin
            rd_data_r <= mem_r[bus.req_addr];
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                  out_valid_r;
         logic [DATA_WIDTH-1:0] out_data_r;

         // Optional second stage, pipelined one response per cycle.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               out_valid_r <= 1'b0;
               out_data_r  <= {DATA_WIDTH{1'b0}};
            end else begin
               out_valid_r <= rd_valid_r;
               if (rd_valid_r) begin
                  out_data_r <= rd_data_r;
               end
            end
         end

         assign rsp_valid_s = out_valid_r;
         assign rsp_rdata_s = out_data_r;
      end else begin : g_no_out_reg
         assign rsp_valid_s = rd_valid_r;
         assign rsp_rdata_s = rd_data_r;
      end
   endgenerate

   assign bus.req_ready = req_ready_s;
   assign bus.init_busy = (state_r == ST_CLEAR);
   assign bus.rsp_valid = rsp_valid_s;
   assign bus.rsp_rdata = rsp_rdata_s;
endmodule

// File: tb/tb_sram_bank.sv
// Bench for sram_bank: OUT_REG=0 and OUT_REG=1 instances share stimulus; a
// per-instance scoreboard queue checks data and arrival cycle of every read.
module tb_sram_bank;
   localparam int          AW    = 4;
   localparam int          DW    = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] INIT  = 32'hC0FF_EE00;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we    = 1'b0;
   logic [3:0]  req_addr  = 4'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [3:0]  req_be    = 4'h0;
   logic        clr_start = 1'b0;

   typedef struct packed {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        q [2][$];
   logic [31:0] last [2];
   logic [31:0] mem_m [DEPTH];
   int          cyc    = 0;
   int          errors = 0;
   int          checks = 0;

   sram_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
   sram_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

   assign if0.req_valid = req_valid;
   assign if0.req_we    = req_we;
   assign if0.req_addr  = req_addr;
   assign if0.req_wdata = req_wdata;
   assign if0.req_be    = req_be;
   assign if0.clr_start = clr_start;
   assign if1.req_valid = req_valid;
   assign if1.req_we    = req_we;
   assign if1.req_addr  = req_addr;
   assign if1.req_wdata = req_wdata;
   assign if1.req_be    = req_be;
   assign if1.clr_start = clr_start;

   sram_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .INIT_VALUE(INIT)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(if0));
   sram_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .INIT_VALUE(INIT)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(if1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic monitor_loop();
      exp_t        e;
      logic        vld;
      logic [31:0] dat;
      forever begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            vld = (p == 0) ? if0.rsp_valid : if1.rsp_valid;
            dat = (p == 0) ? if0.rsp_rdata : if1.rsp_rdata;
            if (vld === 1'b1) begin
               checks++;
               if (q[p].size() == 0) begin
                  errors++;
                  $display("FAIL rsp_unexpected dut%0d: got rsp_valid with rdata=%h at cycle %0d, required no response",
                           p, dat, cyc);
               end else begin
                  e = q[p].pop_front();
                  last[p] = e.data;
                  if (dat !== e.data || cyc != e.due) begin
                     errors++;
                     $display("FAIL rsp_data dut%0d: got rdata=%h at cycle %0d, required %h at cycle %0d",
                              p, dat, cyc, e.data, e.due);
                  end
               end
            end else begin
               if (q[p].size() > 0 && q[p][0].due <= cyc) begin
                  checks++;
                  errors++;
                  e = q[p].pop_front();
                  $display("FAIL rsp_missing dut%0d: got no rsp_valid at cycle %0d, required rdata=%h",
                           p, cyc, e.data);
               end
               checks++;
               if (dat !== last[p]) begin
                  errors++;
                  $display("FAIL rdata_hold dut%0d: got rdata=%h while idle, required %h", p, dat, last[p]);
               end
            end
         end
      end
   endtask

   task automatic slot();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         slot();
         req_valid = 1'b0;
         clr_start = 1'b0;
      end
   endtask

   task automatic issue(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
      exp_t e;
      slot();
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_be    = b;
      clr_start = 1'b0;
      #1;
      checks++;
      if (if0.req_ready !== 1'b1 || if1.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_idle: got %b/%b, required 1/1", if0.req_ready, if1.req_ready);
      end
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (b[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
         end
      end else begin
         e.data = mem_m[a];
         e.due  = cyc + 1;
         q[0].push_back(e);
         e.due  = cyc + 2;
         q[1].push_back(e);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
   endtask

   task automatic count_busy(input int pulse_at, output int n0, output int n1);
      n0 = 0;
      n1 = 0;
      #1;
      for (int k = 0; k < 40; k++) begin
         if (if0.init_busy !== 1'b1 && if1.init_busy !== 1'b1) break;
         if (if0.init_busy === 1'b1) n0++;
         if (if1.init_busy === 1'b1) n1++;
         checks++;
         if ((if0.init_busy === 1'b1 && if0.req_ready !== 1'b0) ||
             (if1.init_busy === 1'b1 && if1.req_ready !== 1'b0)) begin
            errors++;
            $display("FAIL ready_in_clear: got req_ready=%b/%b during sweep, required 0/0",
                     if0.req_ready, if1.req_ready);
         end
         slot();
         clr_start = (k + 1 == pulse_at);
         #1;
      end
      clr_start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      logic [69:0] obs;
      logic [69:0] req;
      obs = {if0.rsp_valid, if1.rsp_valid, if0.rsp_rdata, if1.rsp_rdata,
             if0.req_ready, if1.req_ready, if0.init_busy, if1.init_busy};
      req = {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs !== req) begin
         errors++;
         $display("FAIL %s: got outputs %h, required %h", name, obs, req);
      end
   endtask

   task automatic check_sweep(input string name, input int n0, input int n1);
      checks++;
      if (n0 != DEPTH || n1 != DEPTH) begin
         errors++;
         $display("FAIL %s: got init_busy for %0d/%0d cycles, required %0d", name, n0, n1, DEPTH);
      end
      #1;
      checks++;
      if (if0.req_ready !== 1'b1 || if1.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready: got req_ready=%b/%b after sweep, required 1/1", name, if0.req_ready, if1.req_ready);
      end
   endtask

   task automatic test_reset();
      int n0, n1;
      repeat (3) slot();
      check_reset_outputs("reset_outputs");
      rst_n = 1'b1;
      model_clear();
      count_busy(0, n0, n1);
      check_sweep("reset_sweep", n0, n1);
   endtask

   task automatic test_init_reads();
      for (int a = 0; a < DEPTH; a++) issue(1'b0, 4'(a), 32'h0, 4'h0);
      idle(3);
   endtask

   task automatic test_byte_write();
      issue(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF);
      issue(1'b0, 4'd3, 32'h0, 4'h0);
      issue(1'b1, 4'd3, 32'h00AA_0000, 4'h4);
      issue(1'b0, 4'd3, 32'h0, 4'h0);
      issue(1'b1, 4'd3, 32'hFFFF_FFFF, 4'h0);
      issue(1'b0, 4'd3, 32'h0, 4'h0);
      issue(1'b1, 4'd12, 32'h1234_5678, 4'h9);
      issue(1'b0, 4'd12, 32'h0, 4'h0);
      idle(3);
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 4'd1, 32'h0000_0011, 4'hF);
      issue(1'b1, 4'd2, 32'h0000_0022, 4'hF);
      issue(1'b1, 4'd3, 32'h0000_0033, 4'hF);
      issue(1'b0, 4'd1, 32'h0, 4'h0);
      issue(1'b0, 4'd2, 32'h0, 4'h0);
      issue(1'b0, 4'd3, 32'h0, 4'h0);
      idle(4);
   endtask

   task automatic test_raw();
      issue(1'b1, 4'd7, 32'h5A5A_5A5A, 4'hF);
      issue(1'b0, 4'd7, 32'h0, 4'h0);
      idle(3);
   endtask

   task automatic test_clear();
      int n0, n1;
      issue(1'b0, 4'd7, 32'h0, 4'h0);
      slot();
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 4'd2;
      clr_start = 1'b1;
      #1;
      checks++;
      if (if0.req_ready !== 1'b0 || if1.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_priority: got req_ready=%b/%b with clr_start, required 0/0", if0.req_ready, if1.req_ready);
      end
      model_clear();
      slot();
      req_valid = 1'b0;
      clr_start = 1'b0;
      count_busy(5, n0, n1);
      check_sweep("clear_sweep", n0, n1);
      issue(1'b0, 4'd7, 32'h0, 4'h0);
      issue(1'b0, 4'd2, 32'h0, 4'h0);
      idle(3);
   endtask

   task automatic test_reset_in_flight();
      int n0, n1;
      issue(1'b1, 4'd5, 32'hA5A5_0F0F, 4'hF);
      issue(1'b0, 4'd5, 32'h0, 4'h0);
      slot();
      req_valid = 1'b0;
      rst_n     = 1'b0;
      q[1].delete();
      last[0] = 32'h0;
      last[1] = 32'h0;
      slot();
      check_reset_outputs("reset_in_flight");
      rst_n = 1'b1;
      model_clear();
      repeat (8) slot();
      rst_n = 1'b0;
      slot();
      check_reset_outputs("reset_mid_sweep");
      rst_n = 1'b1;
      count_busy(0, n0, n1);
      check_sweep("restart_sweep", n0, n1);
      issue(1'b0, 4'd5, 32'h0, 4'h0);
      issue(1'b0, 4'd15, 32'h0, 4'h0);
      idle(4);
   endtask

   initial begin
      last[0] = 32'h0;
      last[1] = 32'h0;
      fork
         monitor_loop();
      join_none
      test_reset();
      test_init_reads();
      test_byte_write();
      test_back_to_back();
      test_raw();
      test_clear();
      test_reset_in_flight();
      checks++;
      if (q[0].size() != 0 || q[1].size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d responses outstanding, required 0/0", q[0].size(), q[1].size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sram_bank.md
SRAM_BANK -- requirements
Module: sram_bank

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set word address width; depth = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set word width and SHALL be a multiple of 8.
REQ-003 Parameter OUT_REG, default 0, SHALL select read latency: 0 -> 1 cycle, 1 -> 2 cycles.
REQ-004 Parameter INIT_VALUE, default 0, width DATA_WIDTH, SHALL be the word written by the clear sweep.
REQ-005 Clocking SHALL be one clock with a synchronous, active-low reset.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  bank accepts a request this cycle.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_WIDTH  word address.
REQ-012 req_wdata  input  DATA_WIDTH  write data.
REQ-013 req_be  input  DATA_WIDTH/8  byte enables; bit i enables byte [8i+7:8i].
REQ-014 clr_start  input  1  one-cycle pulse requesting a full-array clear.
REQ-015 init_busy  output  1  clear sweep in progress.
REQ-016 rsp_valid  output  1  read data valid, one-cycle pulse per read.
REQ-017 rsp_rdata  output  DATA_WIDTH  read data.

Function
REQ-018 The FSM SHALL have two states: CLEAR and READY.
- CLEAR: one word per cycle, sweep counter 0 -> depth-1.
- After the write to depth-1, the FSM SHALL go to READY on the next edge.
- A full sweep SHALL take exactly depth cycles.
REQ-019 In CLEAR, the bank SHALL write INIT_VALUE to all bytes of the addressed word.
REQ-020 In CLEAR, init_busy SHALL be 1 and req_ready SHALL be 0.
REQ-021 In READY, init_busy SHALL be 0.
REQ-022 In READY, req_ready SHALL be 1 except when clr_start = 1 (combinational).
REQ-023 clr_start in READY SHALL move the FSM to CLEAR with the counter at 0.
- It SHALL take priority over a same-cycle req_valid; that request SHALL NOT be accepted.
REQ-024 clr_start during CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-025 A request SHALL be accepted on the edge where req_valid && req_ready.
REQ-026 Accepted write: on that edge, each byte with req_be[i] = 1 SHALL take req_wdata; other bytes SHALL be unchanged.
- req_be = 0 SHALL leave memory unchanged.
- A write SHALL produce no response.
REQ-027 Accepted read, OUT_REG = 0: rsp_valid = 1 and rsp_rdata = mem[addr] in cycle T+1.
REQ-028 Accepted read, OUT_REG = 1: rsp_valid = 1 and rsp_rdata = mem[addr] in cycle T+2.
- The extra stage SHALL be a second register; back-to-back reads SHALL be fully pipelined, one response per cycle.
REQ-029 A read accepted on the cycle after a write to the same address SHALL return the newly written bytes.
REQ-030 rsp_rdata SHALL hold its last response value while rsp_valid = 0.
REQ-031 Reads already in the response pipeline when clr_start is taken SHALL still complete with their pre-clear data.
REQ-032 Read responses SHALL return in acceptance order; one port, one access per cycle.

Reset
REQ-033 While rst_n = 0 at a clock edge:
- FSM SHALL enter CLEAR with the counter at 0.
- Pipeline valid bits SHALL clear.
- Outputs SHALL be: rsp_valid = 0, rsp_rdata = 0, req_ready = 0, init_busy = 1.
REQ-034 Reset during a sweep, or with reads in flight, SHALL discard in-flight reads (no rsp_valid) and restart the sweep at 0 after release.
REQ-035 Array contents SHALL NOT be reset directly; they SHALL be initialised only by the sweep.

Verification
REQ-036 Bench parameters: ADDR_WIDTH = 4, DATA_WIDTH = 32. Scenarios:
- Release rst_n -> init_busy = 1 for exactly 16 cycles, then req_ready = 1; reads of addresses 0..15 all return INIT_VALUE.
- Write 0xDEADBEEF to addr 3 with be = 0xF, then write 0x00AA0000 to addr 3 with be = 0x4 -> read addr 3 returns 0xDEADBEEF, then 0xDEAABEEF.
- OUT_REG = 1: back-to-back reads of addrs 1, 2, 3 holding 0x11, 0x22, 0x33 -> rsp_valid high 3 consecutive cycles starting T+2, data 0x11, 0x22, 0x33.
- Write 0x5A5A5A5A to addr 7 at T, read addr 7 at T+1 -> rsp_rdata = 0x5A5A5A5A at T+2 (OUT_REG = 0).
- clr_start with req_valid = 1 in the same cycle -> req_ready = 0, request not accepted, init_busy = 1 for 16 cycles; a second clr_start at sweep cycle 5 does not extend the sweep.
- rst_n asserted at sweep cycle 8 with a read in flight -> no rsp_valid; after release init_busy = 1 for a full 16 cycles.
